// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the registered RV immediate generator.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpImm32   = 7'b0011011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpOp32    = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and decode-side valid/ready bundle of the immediate generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
) ();
    import imm_gen_pipe_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_type;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal,
        out_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal,
        out_target
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: classifies the format, extends to XLEN, flags illegal opcodes.
module imm_gen_pipe_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32     = '0;
        type_o    = ImmNone;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OpLoad, OpImm, OpJalr: begin
                type_o = ImmI;
                imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OpImm32: begin
                if (XLEN == 64) begin
                    type_o = ImmI;
                    imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OpStore: begin
                type_o = ImmS;
                imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OpBranch: begin
                type_o = ImmB;
                imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                type_o = ImmU;
                imm32  = {instr_i[31:12], 12'b0};
            end
            OpJal: begin
                type_o = ImmJ;
                imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
            end
            OpSystem: begin
                // funct3[2] selects the CSR-immediate forms; the rest carry no immediate
                if (instr_i[14]) begin
                    type_o = ImmZ;
                    imm32  = {27'b0, instr_i[19:15]};
                end
            end
            OpOp, OpMiscMem: ;
            OpOp32: illegal_o = (XLEN != 64);
            default: illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        if (type_o == ImmZ) begin
            imm_o = XLEN'(imm32);
        end else begin
            imm_o = XLEN'($signed(imm32));
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode + target adder ahead of a 2-entry skid/output pair.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned GEN_TARGET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_type_e       ty;
        logic            illegal;
    } beat_t;

    beat_t           in_beat;
    beat_t           skid_q, skid_d, out_q, out_d;
    logic            skid_valid_q, skid_valid_d;
    logic            out_valid_q, out_valid_d;
    logic            accept, out_load;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;

    imm_gen_pipe_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_i  (bus.in_instr),
        .imm_o    (dec_imm),
        .type_o   (dec_type),
        .illegal_o(dec_illegal)
    );

    always_comb begin
        in_beat.instr   = bus.in_instr;
        in_beat.pc      = bus.in_pc;
        in_beat.imm     = dec_imm;
        in_beat.ty      = dec_type;
        in_beat.illegal = dec_illegal;
        in_beat.target  = (GEN_TARGET != 0) ? bus.in_pc + dec_imm : '0;
    end

    // in_ready depends only on flops and flush, never on out_ready
    assign bus.in_ready = !skid_valid_q && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_load     = !out_valid_q || bus.out_ready;

    always_comb begin
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        if (flush) begin
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = in_beat;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = in_beat;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_type    = out_q.ty;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_target  = out_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vector tables (RV32 and RV64), handshake corner cases and a
// randomized stream scored against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush64 = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .GEN_TARGET(1)) dut32 (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .GEN_TARGET(1)) dut64 (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush64),
        .bus  (bus64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        imm_type_e   ty;
        logic        ill;
        logic [63:0] tgt;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    vec_t        q[$];
    logic [31:0] emitted[$];
    vec_t        v32[11];
    vec_t        v64[3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return ((v >> (w - 1)) & 1) != 0 ? v - (longint'(1) << w) : v;
    endfunction

    // Reference: field value interpreted as a two's-complement number, scaled, wrapped to xlen
    function automatic vec_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        vec_t        e;
        longint      v;
        logic [63:0] mask;
        v     = 0;
        e.ty  = ImmNone;
        e.ill = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin e.ty = ImmI; v = sx(ins[31:20], 12); end
            7'b0011011: begin
                if (xlen == 64) begin e.ty = ImmI; v = sx(ins[31:20], 12); end
                else e.ill = 1'b1;
            end
            7'b0100011: begin e.ty = ImmS; v = sx({ins[31:25], ins[11:7]}, 12); end
            7'b1100011: begin
                e.ty = ImmB;
                v    = sx({ins[31], ins[7], ins[30:25], ins[11:8]}, 12) * 2;
            end
            7'b0110111, 7'b0010111: begin e.ty = ImmU; v = sx(ins[31:12], 20) * 4096; end
            7'b1101111: begin
                e.ty = ImmJ;
                v    = sx({ins[31], ins[19:12], ins[20], ins[30:21]}, 20) * 2;
            end
            7'b1110011: if (ins[14]) begin e.ty = ImmZ; v = longint'(ins[19:15]); end
            7'b0110011, 7'b0001111: ;
            7'b0111011: e.ill = (xlen != 64);
            default: e.ill = 1'b1;
        endcase
        mask    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.instr = ins;
        e.pc    = pc & mask;
        e.imm   = 64'(v) & mask;
        e.tgt   = (e.pc + e.imm) & mask;
        return e;
    endfunction

    // One cycle on the RV32 instance: drive at negedge, check against the model, advance model.
    task automatic step(input logic fl, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy);
        logic exp_rdy;
        @(negedge clk);
        flush           = fl;
        bus32.in_valid  = v;
        bus32.in_instr  = ins;
        bus32.in_pc     = pc;
        bus32.out_ready = ordy;
        #1;
        exp_rdy = !fl && (q.size() < 2);
        chk("in_ready", 64'(bus32.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus32.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_instr", 64'(bus32.out_instr), 64'(q[0].instr));
            chk("out_pc", 64'(bus32.out_pc), q[0].pc);
            chk("out_imm", 64'(bus32.out_imm), q[0].imm);
            chk("out_type", 64'(bus32.out_type), 64'(q[0].ty));
            chk("out_illegal", 64'(bus32.out_illegal), 64'(q[0].ill));
            chk("out_target", 64'(bus32.out_target), q[0].tgt);
        end
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) begin
                emitted.push_back(q[0].instr);
                void'(q.pop_front());
            end
            if (v && exp_rdy) q.push_back(model(ins, {32'b0, pc}, 32));
        end
    endtask

    task automatic run64(input vec_t t);
        vec_t e;
        e = model(t.instr, t.pc, 64);
        @(negedge clk);
        bus64.in_valid = 1'b1;
        bus64.in_instr = t.instr;
        bus64.in_pc    = t.pc;
        #1;
        chk("in_ready64", 64'(bus64.in_ready), 64'd1);
        @(negedge clk);
        bus64.in_valid = 1'b0;
        #1;
        chk("out_valid64", 64'(bus64.out_valid), 64'd1);
        chk("imm64_tbl", bus64.out_imm, t.imm);
        chk("imm64_model", bus64.out_imm, e.imm);
        chk("type64", 64'(bus64.out_type), 64'(t.ty));
        chk("illegal64", 64'(bus64.out_illegal), 64'(t.ill));
        chk("target64", bus64.out_target, t.tgt);
    endtask

    logic [6:0] ops[14];

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [31:0] seq[4];

        v32[0]  = '{32'hFFF00093, 64'h0,        64'hFFFFFFFF, ImmI,    1'b0, 64'hFFFFFFFF};
        v32[1]  = '{32'hFE112E23, 64'h200,      64'hFFFFFFFC, ImmS,    1'b0, 64'h1FC};
        v32[2]  = '{32'hFE000CE3, 64'h100,      64'hFFFFFFF8, ImmB,    1'b0, 64'hF8};
        v32[3]  = '{32'h0010006F, 64'h1000,     64'h800,      ImmJ,    1'b0, 64'h1800};
        v32[4]  = '{32'h3002D073, 64'h40,       64'h5,        ImmZ,    1'b0, 64'h45};
        v32[5]  = '{32'h00000000, 64'h80,       64'h0,        ImmNone, 1'b1, 64'h80};
        v32[6]  = '{32'h002081B3, 64'h84,       64'h0,        ImmNone, 1'b0, 64'h84};
        v32[7]  = '{32'h12345037, 64'h10,       64'h12345000, ImmU,    1'b0, 64'h12345010};
        v32[8]  = '{32'h00000073, 64'h20,       64'h0,        ImmNone, 1'b0, 64'h20};
        v32[9]  = '{32'hFFF0009B, 64'h30,       64'h0,        ImmNone, 1'b1, 64'h30};
        v32[10] = '{32'h80000017, 64'h10000000, 64'h80000000, ImmU,    1'b0, 64'h90000000};

        v64[0] = '{32'h800000B7, 64'h0,   64'hFFFFFFFF80000000, ImmU, 1'b0, 64'hFFFFFFFF80000000};
        v64[1] = '{32'hFFF0009B, 64'h100, 64'hFFFFFFFFFFFFFFFF, ImmI, 1'b0, 64'hFF};
        v64[2] = '{32'h0000003B, 64'h8,   64'h0,                ImmNone, 1'b0, 64'h8};

        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011, 7'b0001111,
                7'b0111011, 7'b1111111};

        bus32.in_valid  = 1'b0;
        bus32.in_instr  = '0;
        bus32.in_pc     = '0;
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = '0;
        bus64.in_pc     = '0;
        bus64.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("rst_out_imm", 64'(bus32.out_imm), 64'd0);
        chk("rst_out_target", 64'(bus32.out_target), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed RV32 table: present, then check the registered result against constants
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, v32[i].instr, v32[i].pc[31:0], 1'b1);
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            chk("tbl_imm", 64'(bus32.out_imm), v32[i].imm);
            chk("tbl_type", 64'(bus32.out_type), 64'(v32[i].ty));
            chk("tbl_illegal", 64'(bus32.out_illegal), 64'(v32[i].ill));
            chk("tbl_target", 64'(bus32.out_target), v32[i].tgt);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++) run64(v64[i]);

        // Back-pressure: 4 beats, out_ready low for 3 cycles
        seq = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        emitted.delete();
        step(1'b0, 1'b1, seq[0], 32'h400, 1'b0);
        step(1'b0, 1'b1, seq[1], 32'h404, 1'b0);
        step(1'b0, 1'b1, seq[2], 32'h408, 1'b0);
        chk("bp_in_ready_low", 64'(bus32.in_ready), 64'd0);
        step(1'b0, 1'b1, seq[2], 32'h408, 1'b1);
        step(1'b0, 1'b1, seq[2], 32'h408, 1'b1);
        step(1'b0, 1'b1, seq[3], 32'h40C, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("bp_count", 64'(emitted.size()), 64'd4);
        for (int i = 0; i < 4 && i < emitted.size(); i++) chk("bp_order", 64'(emitted[i]), 64'(seq[i]));

        // Flush with both entries held and a beat offered
        step(1'b0, 1'b1, 32'h00500293, 32'h500, 1'b0);
        step(1'b0, 1'b1, 32'h00600313, 32'h504, 1'b0);
        step(1'b1, 1'b1, 32'h00700393, 32'h508, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus32.in_ready), 64'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a stalled stream
        step(1'b0, 1'b1, 32'h00800413, 32'h600, 1'b0);
        step(1'b0, 1'b1, 32'h00900493, 32'h604, 1'b0);
        bus32.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus32.in_ready), 64'd1);
        q.delete();
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized stream
        for (int n = 0; n < 600; n++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) ins = $urandom();
            else ins = {r[31:7], ops[$urandom_range(0, 13)]};
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), ins, $urandom(),
                 ($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
